// File: rtl/ll_pkg.sv
// Shared types and constants for the lunar lander control path.
package ll_pkg;

  typedef enum logic [1:0] {
    FLY     = 2'd0,
    LANDED  = 2'd1,
    CRASHED = 2'd2
  } ll_state_t;

  localparam logic [15:0] LL_CRASH_VEL  = 16'h9970;
  localparam logic [15:0] LL_MAX_THRUST = 16'h0005;
  localparam int unsigned LL_CNT_W      = 8;

endpackage

// File: rtl/ll_tick.sv
// Step prescaler: counts 0..PRESCALE-1 while enabled and flags the last count.
module ll_tick
  import ll_pkg::*;
#(
  parameter int unsigned PRESCALE = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tc
);

  localparam logic [LL_CNT_W-1:0] LAST = LL_CNT_W'(PRESCALE - 1);

  logic [LL_CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/ll_control.sv
// Lander control: paces memory updates and latches the touchdown outcome.
module ll_control
  import ll_pkg::*;
#(
  parameter int unsigned PRESCALE   = 25,
  parameter logic [15:0] CRASH_VEL  = LL_CRASH_VEL,
  parameter logic [15:0] MAX_THRUST = LL_MAX_THRUST
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic [15:0] alt_n,
  input  logic [15:0] vel,
  input  logic [15:0] thrust,
  output logic        wen,
  output logic        land,
  output logic        crash,
  output logic        flying
);

  ll_state_t state;
  ll_state_t state_nxt;
  logic      tc;
  logic      tick_en;
  logic      touchdown;
  logic      crash_cond;

  assign tick_en = (state == FLY) && !hold;

  ll_tick #(.PRESCALE(PRESCALE)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en),
    .tc    (tc)
  );

  // Upper digit >= 5 marks a negative ten's-complement BCD velocity.
  assign crash_cond = ((vel[15:12] >= 4'h5) && (vel <= CRASH_VEL)) ||
                      (thrust > MAX_THRUST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FLY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wen       = 1'b0;
    touchdown = 1'b0;
    land      = 1'b0;
    crash     = 1'b0;
    flying    = 1'b0;
    case (state)
      FLY: begin
        flying    = 1'b1;
        wen       = tc && !hold;
        touchdown = wen && (alt_n == 16'h0000);
        if (touchdown) begin
          state_nxt = crash_cond ? CRASHED : LANDED;
        end
      end
      LANDED:  land  = 1'b1;
      CRASHED: crash = 1'b1;
      default: state_nxt = FLY;
    endcase
  end

endmodule

// File: tb/tb_ll_control.sv
// Scoreboard bench for ll_control with a short prescale.
module tb_ll_control;

  localparam int unsigned PRESCALE = 4;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic [15:0] alt_n;
  logic [15:0] vel;
  logic [15:0] thrust;
  logic        wen;
  logic        land;
  logic        crash;
  logic        flying;

  int checks = 0;
  int errors = 0;
  int cyc;
  bit mon_en = 1'b0;

  int       wen_q[$];
  logic [2:0] st_q[$];
  logic [2:0] prev_st = 3'b100;

  ll_control #(.PRESCALE(PRESCALE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (hold),
    .alt_n  (alt_n),
    .vel    (vel),
    .thrust (thrust),
    .wen    (wen),
    .land   (land),
    .crash  (crash),
    .flying (flying)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index since reset release; cycle k follows the k-th rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor: every wen pulse and every status change must match the scoreboard.
  always @(negedge clk) begin
    logic [2:0] cur;
    int         ew;
    logic [2:0] es;
    if (mon_en && rst_n) begin
      if (wen) begin
        checks++;
        if (wen_q.size() == 0) begin
          errors++;
          $display("FAIL wen_unexpected cyc=%0d got wen=1 want wen=0", cyc);
        end else begin
          ew = wen_q.pop_front();
          if (ew != cyc) begin
            errors++;
            $display("FAIL wen_cycle got cyc=%0d want cyc=%0d", cyc, ew);
          end
        end
      end
      cur = {flying, land, crash};
      if (cur !== prev_st) begin
        checks++;
        if (st_q.size() == 0) begin
          errors++;
          $display("FAIL status_unexpected cyc=%0d got fly/land/crash=%b want %b", cyc, cur, prev_st);
        end else begin
          es = st_q.pop_front();
          if (cur !== es) begin
            errors++;
            $display("FAIL status cyc=%0d got fly/land/crash=%b want %b", cyc, cur, es);
          end
        end
        prev_st = cur;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 200) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout got cyc=%0d want cyc=%0d", cyc, n);
    end
  endtask

  // Half-cycle reset pulse; outputs must return to reset values asynchronously.
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wen", 32'(wen), 32'd0);
    chk("rst_land", 32'(land), 32'd0);
    chk("rst_crash", 32'(crash), 32'd0);
    chk("rst_flying", 32'(flying), 32'd1);
    chk("rst_cnt", 32'(dut.u_tick.cnt), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b1;
    hold   = 1'b0;
    alt_n  = 16'h4500;
    vel    = 16'h0050;
    thrust = 16'h0000;
    #3;

    // Free-running steps, then a hold at the terminal count.
    do_reset();
    wen_q.push_back(3);
    wen_q.push_back(7);
    wen_q.push_back(11);
    wait_cyc(15);
    hold = 1'b1;
    wen_q.push_back(20);
    wait_cyc(17);
    chk("hold_cnt", 32'(dut.u_tick.cnt), 32'd3);
    chk("hold_wen", 32'(wen), 32'd0);
    wait_cyc(20);
    hold = 1'b0;

    // Safe landing at the thrust limit, then 20 idle cycles with no wen.
    wait_cyc(24);
    alt_n  = 16'h0000;
    vel    = 16'h9985;
    thrust = 16'h0005;
    wen_q.push_back(24);
    st_q.push_back(3'b010);
    wait_cyc(26);
    chk("land_land", 32'(land), 32'd1);
    chk("land_crash", 32'(crash), 32'd0);
    chk("land_flying", 32'(flying), 32'd0);
    hold = 1'b1;
    wait_cyc(30);
    hold = 1'b0;
    wait_cyc(46);

    // Velocity exactly at the crash threshold.
    do_reset();
    st_q.push_back(3'b100);
    vel    = 16'h9970;
    thrust = 16'h0003;
    wen_q.push_back(3);
    st_q.push_back(3'b001);
    wait_cyc(5);
    chk("vel30_crash", 32'(crash), 32'd1);
    chk("vel30_land", 32'(land), 32'd0);

    // One ft/s slower lands safely.
    do_reset();
    st_q.push_back(3'b100);
    vel = 16'h9971;
    wen_q.push_back(3);
    st_q.push_back(3'b010);
    wait_cyc(5);
    chk("vel29_land", 32'(land), 32'd1);
    chk("vel29_crash", 32'(crash), 32'd0);

    // Zero altitude outside a wen cycle is ignored; excess thrust crashes.
    do_reset();
    st_q.push_back(3'b100);
    alt_n  = 16'h4500;
    vel    = 16'h9990;
    thrust = 16'h0006;
    wen_q.push_back(3);
    wait_cyc(1);
    alt_n = 16'h0000;
    wait_cyc(2);
    alt_n = 16'h4500;
    chk("offstep_flying", 32'(flying), 32'd1);
    wait_cyc(4);
    chk("nonzero_alt_flying", 32'(flying), 32'd1);
    chk("nonzero_alt_land", 32'(land), 32'd0);
    wait_cyc(7);
    alt_n = 16'h0000;
    wen_q.push_back(7);
    st_q.push_back(3'b001);
    wait_cyc(9);
    chk("thrust_crash", 32'(crash), 32'd1);

    // Reset out of CRASHED restarts stepping from zero.
    do_reset();
    st_q.push_back(3'b100);
    alt_n  = 16'h4500;
    vel    = 16'h0000;
    thrust = 16'h0000;
    wen_q.push_back(3);
    wen_q.push_back(7);
    wait_cyc(9);
    chk("final_flying", 32'(flying), 32'd1);

    chk("wen_q_drained", 32'(wen_q.size()), 32'd0);
    chk("st_q_drained", 32'(st_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
